regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file for the processor datapath: two combinational read ports with same-cycle write bypass, two write ports, a hard-wired zero register, a stack pointer with push/pop arithmetic, a program counter with increment/load modes, and a per-register busy scoreboard for hazard detection. It sits between decode (read/issue) and writeback (write), replacing the single-port register bank plus program counter of the earlier generation.

## Interface
- XLEN, 32, data/address width in bits (multiple of 8)
- NREGS, 32, number of architectural registers (power of two, ≥4); AW = $clog2(NREGS)
- SP_IDX, 2, index of the stack-pointer register (≠0)
- PC_STEP, 4, program-counter increment
- RESET_PC, 0, program-counter reset value
- RESET_SP, 0, stack-pointer reset value

- clk  in  1  global clock, rising edge
- reset_b  in  1  asynchronous active-low reset
- rd_addr_a, rd_addr_b  in  AW  read addresses
- rd_data_a, rd_data_b  out  XLEN  read data (combinational, bypassed)
- busy_a, busy_b  out  1  scoreboard bit of rd_addr_a / rd_addr_b
- wr0_en, wr1_en  in  1  write enables
- wr0_addr, wr1_addr  in  AW  write addresses
- wr0_data, wr1_data  in  XLEN  write data
- issue_en  in  1  mark issue_addr busy
- issue_addr  in  AW  destination register being issued
- sp_op  in  2  00 none, 01 push, 10 pop, 11 illegal
- pc_mode  in  2  00 hold, 01 increment, 10 load, 11 illegal
- pc_data  in  XLEN  PC load value
- program_counter  out  XLEN  registered PC
- stack_pointer  out  XLEN  current register[SP_IDX] (registered value, not bypassed)
- err_clr  in  1  clear sticky error flags
- err_zero_wr, err_collision, err_illegal  out  1  sticky error flags

## Operation
- Reset (reset_b low, asynchronous): all registers 0 except register[SP_IDX] = RESET_SP; program_counter = RESET_PC; all busy bits 0; all error flags 0. Combinational outputs follow (rd_data = 0 except SP reads RESET_SP).
- Register 0 always reads 0, never busy; writes to it are dropped and set err_zero_wr.
- Reads: rd_data_x = wr1_data if wr1_en and wr1_addr==rd_addr_x≠0; else wr0_data if wr0_en and wr0_addr==rd_addr_x≠0; else stored value. Same bypass applies to SP_IDX from sp_op result only when no explicit write targets SP.
- Writes: both ports commit at the clock edge. Same nonzero address on both: wr1 wins, err_collision set.
- Stack pointer: push → SP − XLEN/8, pop → SP + XLEN/8, modulo 2^XLEN (wrap, no flag). If any write port targets SP_IDX in the same cycle, the explicit write wins, sp_op is ignored, err_collision set. sp_op=11: SP unchanged, err_illegal set.
- PC: 01 → PC + PC_STEP modulo 2^XLEN; 10 → pc_data; 11 → hold, err_illegal set.
- Scoreboard: busy[r] cleared by any committed write to r (either port); set by issue_en with issue_addr=r≠0. Set and clear on same r in the same cycle: set wins. issue_addr=0 ignored, no error. SP push/pop does not touch busy bits.
- Errors: sticky; err_clr clears all three; a new error event in the same cycle as err_clr wins (flag stays 1).

## Timing
- Read data and busy_x: zero-cycle combinational from addresses and write-port inputs. busy_x reflects the registered scoreboard (not bypassed for same-cycle issue/write).
- Writes, SP update, PC update, busy and error flags: visible one cycle after the enabling edge.
- program_counter, stack_pointer, error flags: registered outputs, no combinational path from inputs.
- Reset assertion mid-cycle clears state immediately regardless of clk; first update occurs on the first rising edge after reset_b deasserts.

## Test plan
- Reset: hold reset_b low with RESET_PC=0x100, RESET_SP=0x8000 → program_counter=0x100, stack_pointer=0x8000, all rd_data 0, busy 0, errors 0.
- Bypass/collision: wr0 (r5,0xAAAA) and wr1 (r5,0x5555) same cycle, rd_addr_a=5 → rd_data_a=0x5555 that cycle, r5=0x5555 next cycle, err_collision=1.
- Zero register: wr0_en to r0 with 0xFFFF_FFFF → rd r0 = 0, err_zero_wr=1; err_clr next cycle → 0.
- Stack: SP=0x0 push → 0xFFFF_FFFC; pop → 0x0; push with wr0 to SP_IDX value 0x1234 → SP=0x1234, err_collision=1.
- PC: increment from 0xFFFF_FFFC → 0x0; load 0x2000 → 0x2000; pc_mode=11 → holds, err_illegal=1.
- Scoreboard: issue r7 → busy_a(r7)=1 next cycle; wr1 to r7 with issue r7 same cycle → busy stays 1; wr0 to r7 alone → busy clears next cycle.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file with write bypass, zero register, stack pointer,
// program counter and a per-register busy scoreboard.
module regfile_mp #(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int SP_IDX  = 2,
  parameter int PC_STEP = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] RESET_SP = '0,
  localparam int AW = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset_b,
  input  logic [AW-1:0]   rd_addr_a,
  input  logic [AW-1:0]   rd_addr_b,
  output logic [XLEN-1:0] rd_data_a,
  output logic [XLEN-1:0] rd_data_b,
  output logic            busy_a,
  output logic            busy_b,
  input  logic            wr0_en,
  input  logic [AW-1:0]   wr0_addr,
  input  logic [XLEN-1:0] wr0_data,
  input  logic            wr1_en,
  input  logic [AW-1:0]   wr1_addr,
  input  logic [XLEN-1:0] wr1_data,
  input  logic            issue_en,
  input  logic [AW-1:0]   issue_addr,
  input  logic [1:0]      sp_op,
  input  logic [1:0]      pc_mode,
  input  logic [XLEN-1:0] pc_data,
  output logic [XLEN-1:0] program_counter,
  output logic [XLEN-1:0] stack_pointer,
  input  logic            err_clr,
  output logic            err_zero_wr,
  output logic            err_collision,
  output logic            err_illegal
);

  localparam logic [AW-1:0]   SP_A     = AW'(SP_IDX);
  localparam logic [XLEN-1:0] SP_DELTA = XLEN'(XLEN / 8);
  localparam logic [XLEN-1:0] PC_INC   = XLEN'(PC_STEP);

  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;

  logic            wr0_live, wr1_live;
  logic            sp_wr, sp_move, sp_upd;
  logic [XLEN-1:0] sp_cur, sp_next;
  logic            ev_zero, ev_coll, ev_ill;

  assign wr0_live = wr0_en && (wr0_addr != '0);
  assign wr1_live = wr1_en && (wr1_addr != '0);
  assign sp_wr    = (wr0_en && (wr0_addr == SP_A)) || (wr1_en && (wr1_addr == SP_A));
  assign sp_move  = (sp_op == 2'b01) || (sp_op == 2'b10);
  assign sp_upd   = sp_move && !sp_wr;
  assign sp_cur   = regs[SP_IDX];

  always_comb begin
    sp_next = sp_cur;
    case (sp_op)
      2'b01:   sp_next = sp_cur - SP_DELTA;
      2'b10:   sp_next = sp_cur + SP_DELTA;
      default: sp_next = sp_cur;
    endcase
  end

  // Bypass priority: wr1, then wr0, then pending SP arithmetic, then storage.
  function automatic logic [XLEN-1:0] read_port(
    input logic [AW-1:0]   addr,
    input logic            w1, input logic [AW-1:0] a1, input logic [XLEN-1:0] d1,
    input logic            w0, input logic [AW-1:0] a0, input logic [XLEN-1:0] d0,
    input logic            spu, input logic [XLEN-1:0] spn,
    input logic [XLEN-1:0] stored
  );
    logic [XLEN-1:0] r;
    r = stored;
    if (addr == '0)                    r = '0;
    else if (w1 && (a1 == addr))       r = d1;
    else if (w0 && (a0 == addr))       r = d0;
    else if (spu && (addr == SP_A))    r = spn;
    return r;
  endfunction

  always_comb begin
    rd_data_a = read_port(rd_addr_a, wr1_en, wr1_addr, wr1_data, wr0_en, wr0_addr,
                          wr0_data, sp_upd, sp_next, regs[rd_addr_a]);
    rd_data_b = read_port(rd_addr_b, wr1_en, wr1_addr, wr1_data, wr0_en, wr0_addr,
                          wr0_data, sp_upd, sp_next, regs[rd_addr_b]);
  end

  assign busy_a        = busy[rd_addr_a];
  assign busy_b        = busy[rd_addr_b];
  assign stack_pointer = regs[SP_IDX];

  assign ev_zero = (wr0_en && (wr0_addr == '0)) || (wr1_en && (wr1_addr == '0));
  assign ev_coll = (wr0_live && wr1_live && (wr0_addr == wr1_addr)) || (sp_wr && sp_move);
  assign ev_ill  = (sp_op == 2'b11) || (pc_mode == 2'b11);

  always_comb begin
    busy_nxt = busy;
    if (wr0_live) busy_nxt[wr0_addr] = 1'b0;
    if (wr1_live) busy_nxt[wr1_addr] = 1'b0;
    if (issue_en && (issue_addr != '0)) busy_nxt[issue_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= (i == SP_IDX) ? RESET_SP : '0;
    end else begin
      if (wr0_live) regs[wr0_addr] <= wr0_data;
      if (wr1_live) regs[wr1_addr] <= wr1_data;
      if (sp_upd)   regs[SP_IDX]   <= sp_next;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      busy            <= '0;
      program_counter <= RESET_PC;
      err_zero_wr     <= 1'b0;
      err_collision   <= 1'b0;
      err_illegal     <= 1'b0;
    end else begin
      busy <= busy_nxt;
      case (pc_mode)
        2'b01:   program_counter <= program_counter + PC_INC;
        2'b10:   program_counter <= pc_data;
        default: program_counter <= program_counter;
      endcase
      // A fresh event outranks a simultaneous clear.
      err_zero_wr   <= (err_zero_wr   && !err_clr) || ev_zero;
      err_collision <= (err_collision && !err_clr) || ev_coll;
      err_illegal   <= (err_illegal   && !err_clr) || ev_ill;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed-vector bench for regfile_mp with RESET_PC=0x100, RESET_SP=0x8000.
module tb_regfile_mp;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            reset_b;
  logic [AW-1:0]   rd_addr_a, rd_addr_b;
  logic [XLEN-1:0] rd_data_a, rd_data_b;
  logic            busy_a, busy_b;
  logic            wr0_en, wr1_en;
  logic [AW-1:0]   wr0_addr, wr1_addr;
  logic [XLEN-1:0] wr0_data, wr1_data;
  logic            issue_en;
  logic [AW-1:0]   issue_addr;
  logic [1:0]      sp_op, pc_mode;
  logic [XLEN-1:0] pc_data, program_counter, stack_pointer;
  logic            err_clr, err_zero_wr, err_collision, err_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_mp #(.XLEN(32), .NREGS(32), .SP_IDX(2), .PC_STEP(4),
               .RESET_PC(32'h100), .RESET_SP(32'h8000)) dut (
    .clk(clk), .reset_b(reset_b),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .busy_a(busy_a), .busy_b(busy_b),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .sp_op(sp_op), .pc_mode(pc_mode), .pc_data(pc_data),
    .program_counter(program_counter), .stack_pointer(stack_pointer),
    .err_clr(err_clr), .err_zero_wr(err_zero_wr),
    .err_collision(err_collision), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  task automatic idle();
    rd_addr_a = '0; rd_addr_b = '0;
    wr0_en = 0; wr0_addr = '0; wr0_data = '0;
    wr1_en = 0; wr1_addr = '0; wr1_data = '0;
    issue_en = 0; issue_addr = '0;
    sp_op = 2'b00; pc_mode = 2'b00; pc_data = '0; err_clr = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_errors();
    idle(); err_clr = 1; step(); idle(); #1;
  endtask

  task automatic test_reset();
    reset_b = 0; idle();
    rd_addr_a = 5'd5; rd_addr_b = 5'd2;
    #23;
    n_checks++; if (program_counter !== 32'h100) begin n_fail++; $display("FAIL reset_pc got %h exp %h", program_counter, 32'h100); end
    n_checks++; if (stack_pointer !== 32'h8000) begin n_fail++; $display("FAIL reset_sp got %h exp %h", stack_pointer, 32'h8000); end
    n_checks++; if (rd_data_a !== 32'h0) begin n_fail++; $display("FAIL reset_rd_a got %h exp 0", rd_data_a); end
    n_checks++; if (rd_data_b !== 32'h8000) begin n_fail++; $display("FAIL reset_rd_sp got %h exp %h", rd_data_b, 32'h8000); end
    n_checks++; if ({busy_a, busy_b, err_zero_wr, err_collision, err_illegal} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags got %b exp 00000", {busy_a, busy_b, err_zero_wr, err_collision, err_illegal}); end
    @(negedge clk); reset_b = 1; step();
  endtask

  task automatic test_bypass_collision();
    idle();
    wr0_en = 1; wr0_addr = 5'd5; wr0_data = 32'hAAAA;
    wr1_en = 1; wr1_addr = 5'd5; wr1_data = 32'h5555;
    rd_addr_a = 5'd5; #1;
    n_checks++; if (rd_data_a !== 32'h5555) begin n_fail++; $display("FAIL bypass_wr1 got %h exp %h", rd_data_a, 32'h5555); end
    step(); idle(); rd_addr_a = 5'd5; #1;
    n_checks++; if (rd_data_a !== 32'h5555) begin n_fail++; $display("FAIL commit_r5 got %h exp %h", rd_data_a, 32'h5555); end
    n_checks++; if (err_collision !== 1'b1) begin n_fail++; $display("FAIL wr_collision got %b exp 1", err_collision); end
    wr0_en = 1; wr0_addr = 5'd6; wr0_data = 32'h1111; rd_addr_b = 5'd6; #1;
    n_checks++; if (rd_data_b !== 32'h1111) begin n_fail++; $display("FAIL bypass_wr0 got %h exp %h", rd_data_b, 32'h1111); end
    step(); clear_errors();
    n_checks++; if (err_collision !== 1'b0) begin n_fail++; $display("FAIL collision_clr got %b exp 0", err_collision); end
  endtask

  task automatic test_zero_reg();
    idle(); wr0_en = 1; wr0_addr = 5'd0; wr0_data = 32'hFFFF_FFFF; rd_addr_a = 5'd0; #1;
    n_checks++; if (rd_data_a !== 32'h0) begin n_fail++; $display("FAIL zero_bypass got %h exp 0", rd_data_a); end
    step(); idle(); rd_addr_a = 5'd0; #1;
    n_checks++; if (rd_data_a !== 32'h0) begin n_fail++; $display("FAIL zero_read got %h exp 0", rd_data_a); end
    n_checks++; if (err_zero_wr !== 1'b1) begin n_fail++; $display("FAIL zero_err got %b exp 1", err_zero_wr); end
    err_clr = 1; wr1_en = 1; wr1_addr = 5'd0; wr1_data = 32'h1;
    step(); idle(); #1;
    n_checks++; if (err_zero_wr !== 1'b1) begin n_fail++; $display("FAIL clr_vs_event got %b exp 1", err_zero_wr); end
    clear_errors();
    n_checks++; if (err_zero_wr !== 1'b0) begin n_fail++; $display("FAIL zero_clr got %b exp 0", err_zero_wr); end
  endtask

  task automatic test_stack();
    idle(); wr0_en = 1; wr0_addr = 5'd2; wr0_data = 32'h0; step(); idle(); #1;
    n_checks++; if (stack_pointer !== 32'h0) begin n_fail++; $display("FAIL sp_write got %h exp 0", stack_pointer); end
    sp_op = 2'b01; rd_addr_a = 5'd2; #1;
    n_checks++; if (rd_data_a !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL sp_bypass got %h exp %h", rd_data_a, 32'hFFFF_FFFC); end
    n_checks++; if (stack_pointer !== 32'h0) begin n_fail++; $display("FAIL sp_not_bypassed got %h exp 0", stack_pointer); end
    step(); idle(); #1;
    n_checks++; if (stack_pointer !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL sp_push got %h exp %h", stack_pointer, 32'hFFFF_FFFC); end
    sp_op = 2'b10; step(); idle(); #1;
    n_checks++; if (stack_pointer !== 32'h0) begin n_fail++; $display("FAIL sp_pop got %h exp 0", stack_pointer); end
    n_checks++; if (err_collision !== 1'b0) begin n_fail++; $display("FAIL sp_wrap_noflag got %b exp 0", err_collision); end
    sp_op = 2'b01; wr0_en = 1; wr0_addr = 5'd2; wr0_data = 32'h1234; rd_addr_a = 5'd2; #1;
    n_checks++; if (rd_data_a !== 32'h1234) begin n_fail++; $display("FAIL sp_wr_bypass got %h exp %h", rd_data_a, 32'h1234); end
    step(); idle(); #1;
    n_checks++; if (stack_pointer !== 32'h1234) begin n_fail++; $display("FAIL sp_wr_wins got %h exp %h", stack_pointer, 32'h1234); end
    n_checks++; if (err_collision !== 1'b1) begin n_fail++; $display("FAIL sp_collision got %b exp 1", err_collision); end
    clear_errors();
    sp_op = 2'b11; step(); idle(); #1;
    n_checks++; if (stack_pointer !== 32'h1234) begin n_fail++; $display("FAIL sp_illegal_hold got %h exp %h", stack_pointer, 32'h1234); end
    n_checks++; if (err_illegal !== 1'b1) begin n_fail++; $display("FAIL sp_illegal_err got %b exp 1", err_illegal); end
    clear_errors();
  endtask

  task automatic test_pc();
    idle(); pc_mode = 2'b10; pc_data = 32'hFFFF_FFFC; step(); idle(); #1;
    n_checks++; if (program_counter !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL pc_load1 got %h exp %h", program_counter, 32'hFFFF_FFFC); end
    pc_mode = 2'b01; step(); idle(); #1;
    n_checks++; if (program_counter !== 32'h0) begin n_fail++; $display("FAIL pc_wrap got %h exp 0", program_counter); end
    pc_mode = 2'b10; pc_data = 32'h2000; step(); idle(); #1;
    n_checks++; if (program_counter !== 32'h2000) begin n_fail++; $display("FAIL pc_load2 got %h exp %h", program_counter, 32'h2000); end
    pc_mode = 2'b01; step(); idle(); #1;
    n_checks++; if (program_counter !== 32'h2004) begin n_fail++; $display("FAIL pc_inc got %h exp %h", program_counter, 32'h2004); end
    pc_mode = 2'b11; pc_data = 32'h7777; step(); idle(); #1;
    n_checks++; if (program_counter !== 32'h2004) begin n_fail++; $display("FAIL pc_illegal_hold got %h exp %h", program_counter, 32'h2004); end
    n_checks++; if (err_illegal !== 1'b1) begin n_fail++; $display("FAIL pc_illegal_err got %b exp 1", err_illegal); end
    clear_errors();
  endtask

  task automatic test_scoreboard();
    idle(); issue_en = 1; issue_addr = 5'd7; rd_addr_a = 5'd7; #1;
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL busy_not_bypassed got %b exp 0", busy_a); end
    step(); idle(); rd_addr_a = 5'd7; #1;
    n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL busy_set got %b exp 1", busy_a); end
    wr1_en = 1; wr1_addr = 5'd7; wr1_data = 32'h77; issue_en = 1; issue_addr = 5'd7;
    step(); idle(); rd_addr_a = 5'd7; #1;
    n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL busy_set_wins got %b exp 1", busy_a); end
    wr0_en = 1; wr0_addr = 5'd7; wr0_data = 32'h99;
    step(); idle(); rd_addr_a = 5'd7; #1;
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL busy_clear got %b exp 0", busy_a); end
    n_checks++; if (rd_data_a !== 32'h99) begin n_fail++; $display("FAIL r7_value got %h exp %h", rd_data_a, 32'h99); end
    issue_en = 1; issue_addr = 5'd0; step(); idle(); rd_addr_b = 5'd0; #1;
    n_checks++; if ({busy_b, err_zero_wr, err_collision, err_illegal} !== 4'b0) begin
      n_fail++; $display("FAIL issue_r0 got %b exp 0000", {busy_b, err_zero_wr, err_collision, err_illegal}); end
  endtask

  task automatic test_async_reset();
    idle(); issue_en = 1; issue_addr = 5'd7; pc_mode = 2'b10; pc_data = 32'h55;
    step(); idle(); rd_addr_a = 5'd7;
    @(posedge clk); #3; reset_b = 0; #1;
    n_checks++; if (program_counter !== 32'h100) begin n_fail++; $display("FAIL async_pc got %h exp %h", program_counter, 32'h100); end
    n_checks++; if (busy_a !== 1'b0 || rd_data_a !== 32'h0) begin n_fail++; $display("FAIL async_r7 got busy %b data %h exp 0 0", busy_a, rd_data_a); end
    n_checks++; if (stack_pointer !== 32'h8000) begin n_fail++; $display("FAIL async_sp got %h exp %h", stack_pointer, 32'h8000); end
    #2; reset_b = 1; pc_mode = 2'b01; step(); idle(); #1;
    n_checks++; if (program_counter !== 32'h104) begin n_fail++; $display("FAIL post_reset_inc got %h exp %h", program_counter, 32'h104); end
  endtask

  initial begin
    test_reset();
    test_bypass_collision();
    test_zero_reg();
    test_stack();
    test_pc();
    test_scoreboard();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
